drm_ip_activation_gate: RTL and testbench

//   Sits in the ip_core_aclk domain directly downstream of the DRM IP activator.

---
 rtl/drm_ip_activation_gate.sv | 152 +++++++++++++++
 tb/tb_drm_ip_activation_gate.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drm_ip_activation_gate.sv
`default_nettype none
// ============================================================================
// Module      : drm_ip_activation_gate
// Description : Gates the protected user IP from DRM activator status
//               (licensed / time-limited demo / locked). Meters usage units
//               and returns drm_event pulses to the activator.
// Revision    : 1.0 - initial release
// ============================================================================
module drm_ip_activation_gate #(
    parameter int CODE_BIT    = 0,
    parameter int DEMO_CYCLES = 1000000,
    parameter int EVENT_UNITS = 16
) (
    input  logic         ip_core_aclk,
    input  logic         ip_core_arst,
    input  logic         activation_code_ready,
    input  logic         demo_mode,
    input  logic [127:0] activation_code,
    input  logic         usage_unit,
    output logic         ip_enable,
    output logic         demo_expired,
    output logic         drm_event,
    output logic [2:0]   gate_state,
    output logic [31:0]  unit_count
);

    localparam int c_DEMO_W = (DEMO_CYCLES > 1) ? $clog2(DEMO_CYCLES) : 1;
    localparam int c_EV_W   = (EVENT_UNITS > 1) ? $clog2(EVENT_UNITS) : 1;

    localparam logic [c_DEMO_W-1:0] c_DEMO_LAST = c_DEMO_W'(DEMO_CYCLES - 1);
    localparam logic [c_DEMO_W-1:0] c_DEMO_ONE  = c_DEMO_W'(1);
    localparam logic [c_EV_W-1:0]   c_EV_LAST   = c_EV_W'(EVENT_UNITS - 1);
    localparam logic [c_EV_W-1:0]   c_EV_ONE    = c_EV_W'(1);
    localparam logic [31:0]         c_UNIT_MAX  = 32'hFFFF_FFFF;
    localparam logic [31:0]         c_UNIT_ONE  = 32'd1;

    localparam logic [2:0] c_ST_WAIT_CODE    = 3'd0;
    localparam logic [2:0] c_ST_LICENSED     = 3'd1;
    localparam logic [2:0] c_ST_DEMO         = 3'd2;
    localparam logic [2:0] c_ST_DEMO_EXPIRED = 3'd3;
    localparam logic [2:0] c_ST_LOCKED       = 3'd4;

    logic                r_rdy_q;
    logic                r_demo_q;
    logic                r_bit_q;
    logic [2:0]          r_state;
    logic                r_exp;
    logic [c_DEMO_W-1:0] r_demo_cnt;
    logic [c_EV_W-1:0]   r_ev_cnt;
    logic                r_drm_event;
    logic [31:0]         r_unit_count;

    logic [2:0] w_state_nxt;
    logic       w_demo_inc;
    logic       w_set_exp;
    logic       w_lic;
    logic       w_meter;
    logic       w_ev_wrap;
    logic       w_unused_code;

    // Only one bit of the code is decoded; the rest is folded to keep lint quiet.
    assign w_unused_code = ^activation_code;

    always_ff @(posedge ip_core_aclk or posedge ip_core_arst) begin
        if (ip_core_arst) begin
            r_rdy_q  <= 1'b0;
            r_demo_q <= 1'b0;
            r_bit_q  <= 1'b0;
        end else begin
            r_rdy_q  <= activation_code_ready;
            r_demo_q <= demo_mode;
            r_bit_q  <= activation_code[CODE_BIT];
        end
    end

    assign w_lic = r_rdy_q & r_bit_q;

    always_comb begin
        w_state_nxt = r_state;
        w_demo_inc  = 1'b0;
        w_set_exp   = 1'b0;
        case (r_state)
            c_ST_WAIT_CODE: begin
                if (w_lic)                           w_state_nxt = c_ST_LICENSED;
                else if (r_rdy_q && r_demo_q && !r_exp) w_state_nxt = c_ST_DEMO;
                else if (r_rdy_q)                    w_state_nxt = c_ST_LOCKED;
            end
            c_ST_LICENSED: begin
                if (!w_lic) w_state_nxt = c_ST_WAIT_CODE;
            end
            c_ST_DEMO: begin
                // Demo time only advances while the IP actually stays in demo.
                if (w_lic) begin
                    w_state_nxt = c_ST_LICENSED;
                end else if (r_demo_cnt == c_DEMO_LAST) begin
                    w_state_nxt = c_ST_DEMO_EXPIRED;
                    w_set_exp   = 1'b1;
                end else if (!r_rdy_q || !r_demo_q) begin
                    w_state_nxt = c_ST_WAIT_CODE;
                end else begin
                    w_demo_inc  = 1'b1;
                end
            end
            c_ST_DEMO_EXPIRED: begin
                if (w_lic) w_state_nxt = c_ST_LICENSED;
            end
            c_ST_LOCKED: begin
                if (w_lic)         w_state_nxt = c_ST_LICENSED;
                else if (!r_rdy_q) w_state_nxt = c_ST_WAIT_CODE;
            end
            default: w_state_nxt = c_ST_WAIT_CODE;
        endcase
    end

    always_ff @(posedge ip_core_aclk or posedge ip_core_arst) begin
        if (ip_core_arst) begin
            r_state    <= c_ST_WAIT_CODE;
            r_exp      <= 1'b0;
            r_demo_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_set_exp)  r_exp      <= 1'b1;
            if (w_demo_inc) r_demo_cnt <= r_demo_cnt + c_DEMO_ONE;
        end
    end

    // Metering uses the pre-update state, so the exit cycle of LICENSED still counts.
    assign w_meter   = (r_state == c_ST_LICENSED) && usage_unit;
    assign w_ev_wrap = w_meter && (r_ev_cnt == c_EV_LAST);

    always_ff @(posedge ip_core_aclk or posedge ip_core_arst) begin
        if (ip_core_arst) begin
            r_ev_cnt     <= '0;
            r_drm_event  <= 1'b0;
            r_unit_count <= '0;
        end else begin
            r_drm_event <= w_ev_wrap;
            if (w_ev_wrap)    r_ev_cnt <= '0;
            else if (w_meter) r_ev_cnt <= r_ev_cnt + c_EV_ONE;
            if (w_meter && (r_unit_count != c_UNIT_MAX))
                r_unit_count <= r_unit_count + c_UNIT_ONE;
        end
    end

    assign ip_enable    = (r_state == c_ST_LICENSED) || (r_state == c_ST_DEMO);
    assign demo_expired = r_exp;
    assign drm_event    = r_drm_event;
    assign gate_state   = r_state;
    assign unit_count   = r_unit_count;

endmodule
`default_nettype wire

// File: tb/tb_drm_ip_activation_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_drm_ip_activation_gate
// Description : Directed self-checking bench for drm_ip_activation_gate
//               (DEMO_CYCLES=8, EVENT_UNITS=4, CODE_BIT=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drm_ip_activation_gate;

    logic         clk;
    logic         rst;
    logic         activation_code_ready;
    logic         demo_mode;
    logic [127:0] activation_code;
    logic         usage_unit;
    logic         ip_enable;
    logic         demo_expired;
    logic         drm_event;
    logic [2:0]   gate_state;
    logic [31:0]  unit_count;

    int checks   = 0;
    int failures = 0;

    drm_ip_activation_gate #(
        .CODE_BIT    (0),
        .DEMO_CYCLES (8),
        .EVENT_UNITS (4)
    ) u_dut (
        .ip_core_aclk          (clk),
        .ip_core_arst          (rst),
        .activation_code_ready (activation_code_ready),
        .demo_mode             (demo_mode),
        .activation_code       (activation_code),
        .usage_unit            (usage_unit),
        .ip_enable             (ip_enable),
        .demo_expired          (demo_expired),
        .drm_event             (drm_event),
        .gate_state            (gate_state),
        .unit_count            (unit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst                   = 1'b1;
        activation_code_ready = 1'b0;
        demo_mode             = 1'b0;
        activation_code       = '0;
        usage_unit            = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ip_enable, demo_expired, drm_event, gate_state, unit_count} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b exp=%b ev=%b st=%0d cnt=%0d required all 0",
                     ip_enable, demo_expired, drm_event, gate_state, unit_count);
        end
        tick(3);
        checks++;
        if (gate_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_idle_stay got st=%0d required 0", gate_state);
        end
    endtask

    task automatic test_licensed();
        do_reset();
        activation_code_ready = 1'b1;
        activation_code       = 128'd1;
        tick(1);
        checks++;
        if (ip_enable !== 1'b0) begin
            failures++;
            $display("FAIL lic_latency1 got en=%b required 0", ip_enable);
        end
        tick(1);
        checks++;
        if (ip_enable !== 1'b1 || gate_state !== 3'd1) begin
            failures++;
            $display("FAIL lic_enable got en=%b st=%0d required en=1 st=1", ip_enable, gate_state);
        end
        activation_code_ready = 1'b0;
        tick(1);
        checks++;
        if (ip_enable !== 1'b1) begin
            failures++;
            $display("FAIL lic_drop_latency1 got en=%b required 1", ip_enable);
        end
        tick(1);
        checks++;
        if (ip_enable !== 1'b0 || gate_state !== 3'd0) begin
            failures++;
            $display("FAIL lic_drop got en=%b st=%0d required en=0 st=0", ip_enable, gate_state);
        end
    endtask

    task automatic test_demo_expiry();
        int n;
        do_reset();
        activation_code_ready = 1'b1;
        demo_mode             = 1'b1;
        tick(2);
        n = 0;
        while (ip_enable === 1'b1 && n < 20) begin
            n++;
            tick(1);
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL demo_enable_cycles got %0d required 8", n);
        end
        checks++;
        if (gate_state !== 3'd3 || ip_enable !== 1'b0 || demo_expired !== 1'b1) begin
            failures++;
            $display("FAIL demo_expired_state got st=%0d en=%b exp=%b required st=3 en=0 exp=1",
                     gate_state, ip_enable, demo_expired);
        end
        demo_mode = 1'b0;
        tick(3);
        demo_mode = 1'b1;
        tick(3);
        checks++;
        if (gate_state !== 3'd3 || ip_enable !== 1'b0 || demo_expired !== 1'b1) begin
            failures++;
            $display("FAIL demo_toggle_sticky got st=%0d en=%b exp=%b required st=3 en=0 exp=1",
                     gate_state, ip_enable, demo_expired);
        end
    endtask

    task automatic test_metering();
        int events;
        do_reset();
        activation_code_ready = 1'b1;
        activation_code       = 128'd1;
        tick(2);
        for (int k = 1; k <= 9; k++) begin
            usage_unit = 1'b1;
            tick(1);
            usage_unit = 1'b0;
            checks++;
            if (drm_event !== ((k % 4) == 0)) begin
                failures++;
                $display("FAIL meter_event_unit%0d got %b required %b", k, drm_event, (k % 4) == 0);
            end
            tick(1);
            if (k % 4 == 0) begin
                checks++;
                if (drm_event !== 1'b0) begin
                    failures++;
                    $display("FAIL meter_event_width_unit%0d got %b required 0", k, drm_event);
                end
            end
        end
        checks++;
        if (unit_count !== 32'd9) begin
            failures++;
            $display("FAIL meter_count9 got %0d required 9", unit_count);
        end
        // Partial count of 1 is held, so three back-to-back units complete the next group.
        events = 0;
        usage_unit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            if (drm_event === 1'b1) events++;
        end
        usage_unit = 1'b0;
        checks++;
        if (drm_event !== 1'b1 || events != 1 || unit_count !== 32'd12) begin
            failures++;
            $display("FAIL meter_back_to_back got ev=%b events=%0d cnt=%0d required ev=1 events=1 cnt=12",
                     drm_event, events, unit_count);
        end
    endtask

    task automatic test_demo_upgrade();
        int n;
        do_reset();
        activation_code_ready = 1'b1;
        demo_mode             = 1'b1;
        tick(2);
        usage_unit = 1'b1;
        tick(2);
        usage_unit      = 1'b0;
        activation_code = 128'd1;
        tick(2);
        checks++;
        if (gate_state !== 3'd1 || unit_count !== 32'd0) begin
            failures++;
            $display("FAIL upgrade_state got st=%0d cnt=%0d required st=1 cnt=0", gate_state, unit_count);
        end
        activation_code = 128'd0;
        tick(2);
        checks++;
        if (gate_state !== 3'd0) begin
            failures++;
            $display("FAIL upgrade_back_wait got st=%0d required 0", gate_state);
        end
        tick(1);
        n = 0;
        while (ip_enable === 1'b1 && n < 20) begin
            n++;
            tick(1);
        end
        checks++;
        if (n != 5 || gate_state !== 3'd3 || demo_expired !== 1'b1) begin
            failures++;
            $display("FAIL upgrade_remaining_demo got cycles=%0d st=%0d exp=%b required cycles=5 st=3 exp=1",
                     n, gate_state, demo_expired);
        end
    endtask

    task automatic test_locked_and_reset();
        do_reset();
        activation_code_ready = 1'b1;
        tick(2);
        checks++;
        if (gate_state !== 3'd4 || ip_enable !== 1'b0) begin
            failures++;
            $display("FAIL locked_state got st=%0d en=%b required st=4 en=0", gate_state, ip_enable);
        end
        usage_unit = 1'b1;
        tick(4);
        usage_unit = 1'b0;
        tick(1);
        checks++;
        if (drm_event !== 1'b0 || unit_count !== 32'd0) begin
            failures++;
            $display("FAIL locked_no_meter got ev=%b cnt=%0d required ev=0 cnt=0", drm_event, unit_count);
        end
        activation_code = 128'd1;
        tick(2);
        usage_unit = 1'b1;
        tick(3);
        checks++;
        if (gate_state !== 3'd1 || unit_count !== 32'd3 || drm_event !== 1'b0) begin
            failures++;
            $display("FAIL prereset_lic got st=%0d cnt=%0d ev=%b required st=1 cnt=3 ev=0",
                     gate_state, unit_count, drm_event);
        end
        @(posedge clk);
        #1;
        checks++;
        if (drm_event !== 1'b1) begin
            failures++;
            $display("FAIL prereset_event got %b required 1", drm_event);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ip_enable, demo_expired, drm_event, gate_state, unit_count} !== 38'd0) begin
            failures++;
            $display("FAIL async_reset got en=%b exp=%b ev=%b st=%0d cnt=%0d required all 0",
                     ip_enable, demo_expired, drm_event, gate_state, unit_count);
        end
        usage_unit = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        rst                   = 1'b1;
        activation_code_ready = 1'b0;
        demo_mode             = 1'b0;
        activation_code       = '0;
        usage_unit            = 1'b0;
        test_reset();
        test_licensed();
        test_demo_expiry();
        test_metering();
        test_demo_upgrade();
        test_locked_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
